// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    DATA_ST = 2'd1,
    INST_ST = 2'd2
  } arb_state_e;

  // stall bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [7:0]  TIMEOUT_CYCLES = 8'd255;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [3:0]  SEL_WORD       = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_stall_enc.sv
// Priority encoder folding pending bus requests and pipeline stall requests
// into the global stall vector. Purely combinational.
module arb_stall_enc
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_mem,
  input  logic       stallreq_from_ex,
  input  logic       stallreq_from_id,
  input  logic       req_if,
  output logic [5:0] stall
);

  // highest-priority requester picks the stall code
  always_comb begin
    stall = STALL_NONE;
    if (req_mem)               stall = STALL_MEM;
    else if (stallreq_from_ex) stall = STALL_EX;
    else if (stallreq_from_id) stall = STALL_ID;
    else if (req_if)           stall = STALL_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one bus between instruction fetch and
// MEM-stage data accesses, and produces the pipeline stall vector.
// Optional bus watchdog: define ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+------------------------------------------
// IDLE_ST | no bus transaction; arbitrate requests
// DATA_ST | MEM-stage load/store waiting for bus_ack
// INST_ST | instruction fetch waiting for bus_ack
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  output logic [5:0]  stall,
  output logic        bus_ce,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  logic [31:0] rdata_q, inst_q;
  logic        timeout;
  logic        data_ack, inst_ack, data_done, inst_done;
  logic        req_mem, req_if;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES,
  // so bus_err rises TIMEOUT_CYCLES edges after bus_ce.
  assign timeout = (state_q != IDLE_ST) && !bus_ack &&
                   (wait_cnt_q == TIMEOUT_CYCLES - 8'd1);

  // wait counter: cleared while idle (i.e. on entry), counts unacked cycles
  always_ff @(posedge clk) begin
    if (rst)                     wait_cnt_q <= 8'd0;
    else if (state_q == IDLE_ST) wait_cnt_q <= 8'd0;
    else if (!bus_ack)           wait_cnt_q <= wait_cnt_q + 8'd1;
  end

  // one-cycle error pulse following an abort
  always_ff @(posedge clk) begin
    if (rst) bus_err <= 1'b0;
    else     bus_err <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign data_ack  = (state_q == DATA_ST) && bus_ack;
  assign inst_ack  = (state_q == INST_ST) && bus_ack;
  assign data_done = data_ack || ((state_q == DATA_ST) && timeout);
  assign inst_done = inst_ack || ((state_q == INST_ST) && timeout);

  // a requester stops stalling in the cycle its transaction finishes
  assign req_mem = mem_ce && !data_done;
  assign req_if  = if_ce  && !inst_done;

  assign mem_rdata = data_ack ? bus_rdata : rdata_q;
  assign if_inst   = inst_ack ? bus_rdata : inst_q;

  arb_stall_enc u_stall_enc (
    .req_mem          (req_mem),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_id (stallreq_from_id),
    .req_if           (req_if),
    .stall            (stall)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE_ST;
    else     state_q <= state_d;
  end

  // next state: data beats fetch, no preemption, always return through idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_ST: begin
        if (mem_ce)     state_d = DATA_ST;
        else if (if_ce) state_d = INST_ST;
      end
      DATA_ST, INST_ST: begin
        if (bus_ack || timeout) state_d = IDLE_ST;
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // registered bus outputs: launched leaving idle, strobe dropped at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ce    <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b0000;
      bus_addr  <= ZERO_WORD;
      bus_wdata <= ZERO_WORD;
    end else if (state_q == IDLE_ST) begin
      if (mem_ce) begin
        bus_ce    <= 1'b1;
        bus_we    <= mem_we;
        bus_sel   <= mem_sel;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
      end else if (if_ce) begin
        bus_ce    <= 1'b1;
        bus_we    <= 1'b0;
        bus_sel   <= SEL_WORD;
        bus_addr  <= if_addr;
      end
    end else if (bus_ack || timeout) begin
      bus_ce  <= 1'b0;
      bus_we  <= 1'b0;
      bus_sel <= 4'b0000;
    end
  end

  // read-data capture; stores leave rdata_q alone, aborts load zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= ZERO_WORD;
      inst_q  <= ZERO_WORD;
    end else begin
      if (data_ack && !bus_we)                    rdata_q <= bus_rdata;
      else if ((state_q == DATA_ST) && timeout)   rdata_q <= ZERO_WORD;
      if (inst_ack)                               inst_q  <= bus_rdata;
      else if ((state_q == INST_ST) && timeout)   inst_q  <= ZERO_WORD;
    end
  end

endmodule
